axis_axil_master: RTL and testbench
===================================

# axis_axil_master

AXI-Stream-driven AXI-Lite initiator. It accepts command packets on a stream, typically the MM2S DMA stream from the PS, and turns each packet into one AXI-Lite read or write. It returns one status packet per command on an output stream, typically the S2MM DMA stream. It is the PL-side master counterpart to the PS-driven AXI-Lite slave path: it lets stream traffic reach `axil_top` register maps without a PS GP port.

## Interface
- `AXIL_ADDR_WIDTH`, 32: AXI-Lite address width; must be ≤ 32.
- `AXIL_DATA_WIDTH`, 32: AXI-Lite data width; must equal the stream width of 32.
- `TIMEOUT_CYCLES`, 1024: response watchdog limit; used only when `AXIS_AXIL_MASTER_TIMEOUT_EN` is defined.

Ports:
- `clk_i`  in  1  single clock; all interfaces are synchronous to it.
- `arstn_i`  in  1  reset, asynchronous assert, active-low.
- `s_axis`  axis_if slave  32  command stream (tdata, tvalid, tready, tlast).
- `m_axis`  axis_if master  32  status stream.
- `m_axil`  axil_if master  AXIL_ADDR_WIDTH/AXIL_DATA_WIDTH  AXI-Lite initiator port (aw, w, b, ar, r channels).

## Operation
Command packet format:
- Word0 (header): [31] = 1 write / 0 read; [3:0] = wstrb (ignored for reads); [30:4] = 0.
- Word1: address. Bits above AXIL_ADDR_WIDTH are ignored.
- Word2: write data. Present only for writes.
- tlast must be set on the final word (word1 for a read, word2 for a write).

Status packet format:
- Word0: [31] echoes the write flag; [1:0] = BRESP or RRESP; [2] = timeout; [3] = bad command; all other bits 0.
- A write returns word0 only, with tlast set.
- A read always returns word0 then word1 = RDATA, with tlast on word1. RDATA is 0 when bit 2 or bit 3 is set.

State machine:
- `IDLE`: s_axis.tready = 1. On header accept, latch the write flag and wstrb, then go to `ADDR`.
- `ADDR`: capture the address.
  - tlast on a write → bad command, go to `STATUS`.
  - No tlast on a read → go to `DRAIN`.
  - Otherwise go to `WDATA` (write) or `AR` (read).
- `WDATA`: capture the data. No tlast → `DRAIN`, otherwise → `AW_W`.
- `DRAIN`: discard words through tlast, set the bad-command bit, go to `STATUS`. No bus access is made.
- `AW_W`: assert awvalid and wvalid together. Drop each one independently on its own handshake. When both handshakes are done → `B`. awprot = 3'b000.
- `B`: bready = 1. On bvalid, latch bresp → `STATUS`.
- `AR`: assert arvalid until arready → `R`. arprot = 3'b000.
- `R`: rready = 1. On rvalid, latch rresp and rdata → `STATUS`.
- `STATUS`: hold m_axis word0 until tready. Then → `RDATA` for a read, or → `IDLE` for a write.
- `RDATA`: hold word1 with tlast until tready → `IDLE`.

s_axis.tready is 0 in every state except `IDLE`, `ADDR`, `WDATA` and `DRAIN`. Only one transaction is outstanding at a time.

## Timing
- Reset values: all valids 0, bready 0, rready 0, s_axis.tready 0, m_axis tdata/tlast 0, state `IDLE`.
- s_axis.tready rises on the first clock after arstn_i deasserts.
- All outputs are registered.
- Write with zero-wait slave: last command beat at cycle N → awvalid/wvalid at N+1 → handshake at N+1 → B at N+2 with bvalid → status tvalid at N+3.
- Read with zero-wait slave: arvalid at N+1 → rvalid at N+2 → status word0 at N+3, word1 at N+4 if tready is held high.
- AXI rule: no valid is dropped before its handshake completes, except by the watchdog.
- Address and data values are stable while their valid is high.
- Reset mid-transaction: all outputs return to their reset values immediately. No status packet is produced for the interrupted command.
- Back-to-back commands: the next header is accepted in the cycle after the last status beat.

## Configuration
- `AXIS_AXIL_MASTER_TIMEOUT_EN` defined:
  - A counter clears on entry to `AW_W` or `AR` and counts every cycle through `B`/`R`.
  - When it reaches TIMEOUT_CYCLES - 1, all AXI valids and readys drop, bit 2 is set, resp = 2'b10 (SLVERR), and the block goes to `STATUS`.
  - Dropping the valids violates the protocol toward the hung slave. This is accepted and intended.
- Not defined: the counter is absent and the block waits indefinitely. Bit 2 is always 0.

## Structure
- Shared package `axil_master_pkg`:
  - State enum.
  - Header and status bit-position localparams: WR_BIT = 31, TO_BIT = 2, BAD_BIT = 3.
  - Response code constants OKAY, SLVERR, DECERR.
- One sub-module, `axil_timeout_cnt`: counter with clear, enable and an expire pulse. It is instantiated only under the macro.

## Test plan
- Write 0xDEADBEEF to 0x0000_0010, wstrb 0xF, zero-wait slave → AW/W issued with those values; status 0x8000_0000 with tlast, at N+3.
- Read 0x0000_0010 with the slave returning 0xDEADBEEF/OKAY → status 0x0000_0000 then 0xDEADBEEF, tlast on the second word.
- Slave returns BRESP = 2'b11 on a write → status 0x8000_0003.
- Read header whose address word lacks tlast, followed by 2 junk words with tlast on the last → no AR issued; status 0x0000_0008 then 0x0000_0000.
- With the macro defined and the slave never asserting rvalid (TIMEOUT_CYCLES = 16) → rready drops after 16 cycles; status 0x0000_0006 then 0.
- Reset asserted while awvalid is high, wready held low → awvalid drops asynchronously; after release, the next command completes normally.

Source files
------------

// File: rtl/axil_master_pkg.sv
// Shared definitions for the stream-driven AXI-Lite initiator: FSM states,
// header/status bit positions, AXI response codes and the status-word builder.
package axil_master_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    WDATA,
    DRAIN,
    AW_W,
    B,
    AR,
    R,
    STATUS,
    RDATA
  } state_e;

  // Header / status word bit positions
  localparam int WR_BIT  = 31;
  localparam int TO_BIT  = 2;
  localparam int BAD_BIT = 3;

  // AXI response codes
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Assemble status word0: write echo, bad-command flag, timeout flag, response
  function automatic logic [31:0] status_word(input logic       wr,
                                              input logic       bad,
                                              input logic       to,
                                              input logic [1:0] resp);
    logic [31:0] w;
    w          = '0;
    w[WR_BIT]  = wr;
    w[BAD_BIT] = bad;
    w[TO_BIT]  = to;
    w[1:0]     = resp;
    return w;
  endfunction

endpackage

// File: rtl/axil_timeout_cnt.sv
// Response watchdog: counts enabled cycles and flags expiry once the count
// reaches LIMIT-1. Held at zero whenever clr is high.
module axil_timeout_cnt #(
  parameter int LIMIT = 1024
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // Cycle counter, cleared between bus transactions
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/axis_axil_master.sv
// AXI-Stream command packets -> single AXI-Lite read/write -> status packet.
// Optional response watchdog enabled by defining AXIS_AXIL_MASTER_TIMEOUT_EN.
module axis_axil_master
  import axil_master_pkg::*;
#(
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                         clk_i,
  input  logic                         arstn_i,
  // Command stream
  input  logic [31:0]                  s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  // Status stream
  output logic [31:0]                  m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  // AXI-Lite initiator
  output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic [2:0]                   m_axil_awprot,
  output logic                         m_axil_awvalid,
  input  logic                         m_axil_awready,
  output logic [AXIL_DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                         m_axil_wvalid,
  input  logic                         m_axil_wready,
  input  logic [1:0]                   m_axil_bresp,
  input  logic                         m_axil_bvalid,
  output logic                         m_axil_bready,
  output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic [2:0]                   m_axil_arprot,
  output logic                         m_axil_arvalid,
  input  logic                         m_axil_arready,
  input  logic [AXIL_DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]                   m_axil_rresp,
  input  logic                         m_axil_rvalid,
  output logic                         m_axil_rready
);

  state_e                       state;
  logic                         is_wr;
  logic [AXIL_DATA_WIDTH/8-1:0] strb_q;
  logic [AXIL_ADDR_WIDTH-1:0]   addr_q;
  logic [AXIL_DATA_WIDTH-1:0]   wdata_q;
  logic [AXIL_DATA_WIDTH-1:0]   rdata_q;
  logic                         s_hs;
  logic                         bus_active;
  logic                         expire;

  assign s_hs       = s_axis_tvalid && s_axis_tready;
  assign bus_active = (state == AW_W) || (state == B) || (state == AR) || (state == R);

  // Address/data come straight from registers, so they stay stable under valid
  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = strb_q;
  assign m_axil_awprot = 3'b000;
  assign m_axil_arprot = 3'b000;

`ifdef AXIS_AXIL_MASTER_TIMEOUT_EN
  // Watchdog runs only while a bus transaction is in flight
  axil_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .clr     (!bus_active),
    .en      (bus_active),
    .expire  (expire)
  );
`else
  logic timeout_unused;
  assign expire         = 1'b0;
  assign timeout_unused = (TIMEOUT_CYCLES == 0);
`endif

  // Command/transaction FSM; every interface output is a register set on transitions
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state          <= IDLE;
      is_wr          <= 1'b0;
      strb_q         <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      s_axis_tready  <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every branch sees the
      // pre-edge values of state and outputs, regardless of statement order.
      case (state)
        IDLE: begin
          s_axis_tready <= 1'b1;
          if (s_hs) begin
            is_wr   <= s_axis_tdata[WR_BIT];
            strb_q  <= s_axis_tdata[AXIL_DATA_WIDTH/8-1:0];
            rdata_q <= '0;
            state   <= ADDR;
          end
        end

        ADDR: begin
          if (s_hs) begin
            addr_q <= s_axis_tdata[AXIL_ADDR_WIDTH-1:0];
            if (is_wr && s_axis_tlast) begin
              s_axis_tready <= 1'b0;
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= status_word(1'b1, 1'b1, 1'b0, OKAY);
              m_axis_tlast  <= 1'b1;
              state         <= STATUS;
            end else if (!is_wr && !s_axis_tlast) begin
              state <= DRAIN;
            end else if (is_wr) begin
              state <= WDATA;
            end else begin
              s_axis_tready  <= 1'b0;
              m_axil_arvalid <= 1'b1;
              state          <= AR;
            end
          end
        end

        WDATA: begin
          if (s_hs) begin
            wdata_q <= s_axis_tdata;
            if (!s_axis_tlast) begin
              state <= DRAIN;
            end else begin
              s_axis_tready  <= 1'b0;
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
              state          <= AW_W;
            end
          end
        end

        DRAIN: begin
          if (s_hs && s_axis_tlast) begin
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= status_word(is_wr, 1'b1, 1'b0, OKAY);
            m_axis_tlast  <= is_wr;
            state         <= STATUS;
          end
        end

        AW_W: begin
          if (expire) begin
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axis_tvalid  <= 1'b1;
            m_axis_tdata   <= status_word(1'b1, 1'b0, 1'b1, SLVERR);
            m_axis_tlast   <= 1'b1;
            state          <= STATUS;
          end else begin
            if (m_axil_awvalid && m_axil_awready) m_axil_awvalid <= 1'b0;
            if (m_axil_wvalid && m_axil_wready)   m_axil_wvalid  <= 1'b0;
            if ((!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready)) begin
              m_axil_bready <= 1'b1;
              state         <= B;
            end
          end
        end

        B: begin
          if (expire || m_axil_bvalid) begin
            m_axil_bready <= 1'b0;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= expire ? status_word(1'b1, 1'b0, 1'b1, SLVERR)
                                    : status_word(1'b1, 1'b0, 1'b0, m_axil_bresp);
            m_axis_tlast  <= 1'b1;
            state         <= STATUS;
          end
        end

        AR: begin
          if (expire) begin
            m_axil_arvalid <= 1'b0;
            m_axis_tvalid  <= 1'b1;
            m_axis_tdata   <= status_word(1'b0, 1'b0, 1'b1, SLVERR);
            m_axis_tlast   <= 1'b0;
            state          <= STATUS;
          end else if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state          <= R;
          end
        end

        R: begin
          if (expire) begin
            m_axil_rready <= 1'b0;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= status_word(1'b0, 1'b0, 1'b1, SLVERR);
            m_axis_tlast  <= 1'b0;
            state         <= STATUS;
          end else if (m_axil_rvalid) begin
            m_axil_rready <= 1'b0;
            rdata_q       <= m_axil_rdata;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= status_word(1'b0, 1'b0, 1'b0, m_axil_rresp);
            m_axis_tlast  <= 1'b0;
            state         <= STATUS;
          end
        end

        STATUS: begin
          if (m_axis_tready) begin
            if (!is_wr) begin
              // rdata_q stays zero for bad commands and timeouts
              m_axis_tdata <= rdata_q;
              m_axis_tlast <= 1'b1;
              state        <= RDATA;
            end else begin
              m_axis_tvalid <= 1'b0;
              m_axis_tdata  <= '0;
              m_axis_tlast  <= 1'b0;
              s_axis_tready <= 1'b1;
              state         <= IDLE;
            end
          end
        end

        RDATA: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            s_axis_tready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_axil_master.sv
// Self-checking bench for axis_axil_master: directed timing/boundary cases,
// then randomized commands against a byte-addressed memory model and a
// scoreboard of expected status beats and bus accesses.
module tb_axis_axil_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;

  always #5 clk = ~clk;

  axis_axil_master #(
    .AXIL_ADDR_WIDTH (AW),
    .AXIL_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk_i          (clk),
    .arstn_i        (arstn),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .s_axis_tlast   (s_tlast),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tlast   (m_tlast),
    .m_axil_awaddr  (awaddr),
    .m_axil_awprot  (awprot),
    .m_axil_awvalid (awvalid),
    .m_axil_awready (awready),
    .m_axil_wdata   (wdata),
    .m_axil_wstrb   (wstrb),
    .m_axil_wvalid  (wvalid),
    .m_axil_wready  (wready),
    .m_axil_bresp   (bresp),
    .m_axil_bvalid  (bvalid),
    .m_axil_bready  (bready),
    .m_axil_araddr  (araddr),
    .m_axil_arprot  (arprot),
    .m_axil_arvalid (arvalid),
    .m_axil_arready (arready),
    .m_axil_rdata   (rdata),
    .m_axil_rresp   (rresp),
    .m_axil_rvalid  (rvalid),
    .m_axil_rready  (rready)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } bus_t;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_status[$];   // {tlast, tdata}
  bus_t        exp_bus[$];
  logic [1:0]  resp_q[$];
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] slave_mem[logic [31:0]];
  int          slave_mode = 0;  // 0 zero-wait, 1 random, 2 stalled, 3 read never answered
  bit          rand_sink = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Status sink readiness
  initial begin : sink_drv
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_sink ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard monitor for status beats
  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (arstn && m_tvalid && m_tready) begin
        check("status beat expected", 64'(exp_status.size() != 0), 64'd1);
        if (exp_status.size() != 0) begin
          e = exp_status.pop_front();
          check("status beat", {31'b0, m_tlast, m_tdata}, {31'b0, e});
        end
      end
    end
  end

  // AXI-Lite slave with its own memory, plus valid-hold / address-stability checks
  initial begin : slave
    bit          aw_f, w_f, b_f, ar_f, r_f;
    bit          got_aw, got_w, got_ar;
    bit          aw_pend, w_pend, ar_pend;
    logic [31:0] aw_a, w_d, ar_a, aw_hold, ar_hold, w_hold, cur;
    logic [3:0]  w_s;
    bus_t        e;
    got_aw = 0; got_w = 0; got_ar = 0;
    aw_pend = 0; w_pend = 0; ar_pend = 0;
    forever begin
      @(negedge clk);
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      b_f  = bvalid && bready;
      ar_f = arvalid && arready;
      r_f  = rvalid && rready;
      if (!arstn) begin
        aw_pend = 0; w_pend = 0; ar_pend = 0;
      end else begin
        if (aw_pend) check("awvalid held, awaddr stable", {31'b0, awvalid, awaddr}, {31'b0, 1'b1, aw_hold});
        if (w_pend)  check("wvalid held, wdata stable", {31'b0, wvalid, wdata}, {31'b0, 1'b1, w_hold});
        if (ar_pend) check("arvalid held, araddr stable", {31'b0, arvalid, araddr}, {31'b0, 1'b1, ar_hold});
        aw_pend = awvalid && !awready; aw_hold = awaddr;
        w_pend  = wvalid && !wready;   w_hold  = wdata;
        ar_pend = arvalid && !arready; ar_hold = araddr;
      end
      @(posedge clk);
      #1;
      if (!arstn) begin
        got_aw = 0; got_w = 0; got_ar = 0;
        bvalid = 0; rvalid = 0;
        awready = 0; wready = 0; arready = 0;
      end else begin
        if (b_f) bvalid = 0;
        if (r_f) rvalid = 0;
        if (aw_f) begin
          got_aw = 1; aw_a = awaddr;
          check("awprot", 64'(awprot), 64'd0);
        end
        if (w_f) begin
          got_w = 1; w_d = wdata; w_s = wstrb;
        end
        if (got_aw && got_w && !bvalid && (slave_mode != 1 || $urandom_range(0, 1) == 1)) begin
          check("write access expected", 64'(exp_bus.size() != 0), 64'd1);
          if (exp_bus.size() != 0) begin
            e = exp_bus.pop_front();
            check("access is a write", 64'(e.wr), 64'd1);
            check("write addr", 64'(aw_a), 64'(e.addr));
            check("write strb/data", {28'b0, w_s, w_d}, {28'b0, e.strb, e.data});
          end
          cur = slave_mem.exists(aw_a) ? slave_mem[aw_a] : 32'h0;
          for (int i = 0; i < 4; i++) if (w_s[i]) cur[8*i +: 8] = w_d[8*i +: 8];
          slave_mem[aw_a] = cur;
          bresp  = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
          bvalid = 1;
          got_aw = 0; got_w = 0;
        end
        if (ar_f) begin
          check("arprot", 64'(arprot), 64'd0);
          check("read access expected", 64'(exp_bus.size() != 0), 64'd1);
          if (exp_bus.size() != 0) begin
            e = exp_bus.pop_front();
            check("access is a read", 64'(e.wr), 64'd0);
            check("read addr", 64'(araddr), 64'(e.addr));
          end
          ar_a   = araddr;
          got_ar = (slave_mode != 3);
        end
        if (got_ar && !rvalid && (slave_mode != 1 || $urandom_range(0, 1) == 1)) begin
          rdata  = slave_mem.exists(ar_a) ? slave_mem[ar_a] : 32'h0;
          rresp  = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
          rvalid = 1;
          got_ar = 0;
        end
        case (slave_mode)
          1: begin
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            arready = 1'($urandom_range(0, 1));
          end
          2: begin awready = 0; wready = 0; arready = 0; end
          default: begin awready = 1; wready = 1; arready = 1; end
        endcase
      end
    end
  end

  // Drive one command beat and return at #1 after the edge that accepted it
  task automatic send_beat(input logic [31:0] d, input bit last);
    int n;
    n        = 0;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) begin
      $display("FAIL s_axis handshake: tready stayed low for %0d cycles", n);
      errors++;
      $fatal(1, "command stream stalled");
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Well-formed command: update the model and queue expected bus access and status
  task automatic do_cmd(input bit wr, input logic [3:0] strb, input logic [31:0] addr,
                        input logic [31:0] data, input logic [1:0] resp);
    bus_t        b;
    logic [31:0] cur;
    cur = model_mem.exists(addr) ? model_mem[addr] : 32'h0;
    if (wr) begin
      for (int i = 0; i < 4; i++) if (strb[i]) cur[8*i +: 8] = data[8*i +: 8];
      model_mem[addr] = cur;
      exp_status.push_back({1'b1, 32'h8000_0000 | 32'(resp)});
    end else begin
      exp_status.push_back({1'b0, 32'(resp)});
      exp_status.push_back({1'b1, cur});
    end
    b.wr = wr; b.addr = addr; b.data = data; b.strb = strb;
    exp_bus.push_back(b);
    resp_q.push_back(resp);
    send_beat({wr, 27'b0, strb}, 1'b0);
    send_beat(addr, !wr);
    if (wr) send_beat(data, 1'b1);
  endtask

  // Read whose address word lacks tlast, followed by junk through tlast
  task automatic bad_read(input int junk);
    exp_status.push_back({1'b0, 32'h0000_0008});
    exp_status.push_back({1'b1, 32'h0000_0000});
    send_beat(32'h0000_0000, 1'b0);
    send_beat(32'h0000_0040, 1'b0);
    for (int i = 0; i < junk; i++) send_beat($urandom, i == junk - 1);
  endtask

  // Write whose address word carries tlast (too short)
  task automatic bad_write_short();
    exp_status.push_back({1'b1, 32'h8000_0008});
    send_beat(32'h8000_000F, 1'b0);
    send_beat(32'h0000_0044, 1'b1);
  endtask

  // Write whose data word lacks tlast, followed by junk through tlast
  task automatic bad_write_long(input int junk);
    exp_status.push_back({1'b1, 32'h8000_0008});
    send_beat(32'h8000_000F, 1'b0);
    send_beat(32'h0000_0048, 1'b0);
    send_beat($urandom, 1'b0);
    for (int i = 0; i < junk; i++) send_beat($urandom, i == junk - 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_status.size() != 0 || exp_bus.size() != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("status queue drained", 64'(exp_status.size()), 64'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL global watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cnt;
    int r;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("reset s_tready", 64'(s_tready), 64'd0);
    check("reset axi valids/readys", {59'b0, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
    check("reset m_axis", {31'b0, m_tvalid, m_tlast, m_tdata}, 64'd0);
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk);
    #1;
    check("s_tready first clock after reset", 64'(s_tready), 64'd1);

    // Directed write, zero-wait slave, exact latency
    do_cmd(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 2'b00);
    check("N+1 awvalid/wvalid", {62'b0, awvalid, wvalid}, 64'd3);
    check("N+1 awaddr", 64'(awaddr), 64'h10);
    check("N+1 wdata/wstrb", {28'b0, wstrb, wdata}, {28'b0, 4'hF, 32'hDEAD_BEEF});
    @(posedge clk); #1;
    check("N+2 bready, no status yet", {62'b0, bready, m_tvalid}, 64'd2);
    @(posedge clk); #1;
    check("N+3 write status", {31'b0, m_tvalid, m_tlast, m_tdata}, {31'b0, 2'b11, 32'h8000_0000});
    wait_drain();

    // Directed read of the same location
    do_cmd(1'b0, 4'h0, 32'h0000_0010, 32'h0, 2'b00);
    check("N+1 arvalid", 64'(arvalid), 64'd1);
    check("N+1 araddr", 64'(araddr), 64'h10);
    @(posedge clk); #1;
    check("N+2 rready", 64'(rready), 64'd1);
    @(posedge clk); #1;
    check("N+3 read word0", {31'b0, m_tvalid, m_tlast, m_tdata}, {31'b0, 2'b10, 32'h0});
    @(posedge clk); #1;
    check("N+4 read word1", {31'b0, m_tvalid, m_tlast, m_tdata}, {31'b0, 2'b11, 32'hDEAD_BEEF});
    wait_drain();

    // Error response and malformed commands
    do_cmd(1'b1, 4'hF, 32'h0000_0020, 32'h1234_5678, 2'b11);
    bad_read(2);
    bad_write_short();
    bad_write_long(2);
    wait_drain();

`ifdef AXIS_AXIL_MASTER_TIMEOUT_EN
    // Slave never answers the read: watchdog ends it after TO cycles
    begin
      bus_t b;
      slave_mode = 3;
      b.wr = 1'b0; b.addr = 32'h0000_0050; b.data = 32'h0; b.strb = 4'h0;
      exp_bus.push_back(b);
      exp_status.push_back({1'b0, 32'h0000_0006});
      exp_status.push_back({1'b1, 32'h0000_0000});
      send_beat(32'h0000_0000, 1'b0);
      send_beat(32'h0000_0050, 1'b1);
      cnt = 0;
      while ((arvalid || rready) && cnt < 100) begin
        cnt++;
        @(posedge clk); #1;
      end
      check("timeout window (arvalid+rready cycles)", 64'(cnt), 64'(TO));
      wait_drain();
      slave_mode = 0;
    end
`endif

    // Reset while awvalid is pending with the slave stalled
    slave_mode = 2;
    @(posedge clk); #1;
    send_beat(32'h8000_000F, 1'b0);
    send_beat(32'h0000_0030, 1'b0);
    send_beat(32'h5555_AAAA, 1'b1);
    check("awvalid pending before reset", 64'(awvalid), 64'd1);
    #2;
    arstn = 1'b0;
    #1;
    check("async reset drops valids", {61'b0, awvalid, wvalid, s_tready}, 64'd0);
    check("async reset clears m_axis", {31'b0, m_tvalid, m_tlast, m_tdata}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arstn = 1'b1;
    slave_mode = 0;
    @(posedge clk); #1;
    do_cmd(1'b1, 4'h3, 32'h0000_0030, 32'hCAFE_F00D, 2'b00);
    do_cmd(1'b0, 4'h0, 32'h0000_0030, 32'h0, 2'b00);
    wait_drain();

    // Randomized traffic with random slave and sink back-pressure
    slave_mode = 1;
    rand_sink  = 1'b1;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      bad_read($urandom_range(1, 3));
      else if (r == 1) bad_write_long($urandom_range(1, 2));
      else             do_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                              32'($urandom_range(0, 7) * 4), $urandom, 2'($urandom_range(0, 3)));
    end
    wait_drain();
    check("bus queue drained", 64'(exp_bus.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
